// File: rtl/dadda_divider_8by4.sv
// Restoring divider 8/4 (inverse of the 4x4 Dadda multiplier): quotient and remainder, one quotient bit per clock.
// Latency: done after start edge N+8; b==0 (and a<b when DADDA_DIV_EARLY_EXIT_EN is defined) after N+1. start is ignored while busy/done.
module dadda_divider_8by4 #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic [VW:0]   p;
  logic [CW-1:0] cnt;
  logic          short_op;

  logic [VW:0]   p_sh;
  logic [VW:0]   p_nx;
  logic          q_bit;
  logic [DW-1:0] dvd_nx;
  logic          skip;
  logic          dvs_zero;

  always_comb begin
    p_sh     = {p[VW-1:0], dvd[DW-1]};
    q_bit    = (p_sh >= {1'b0, dvs});
    p_nx     = q_bit ? (p_sh - {1'b0, dvs}) : p_sh;
    dvd_nx   = {dvd[DW-2:0], q_bit};
    dvs_zero = (dvs == '0);
`ifdef DADDA_DIV_EARLY_EXIT_EN
    skip     = (b == '0) || (a < {{(DW-VW){1'b0}}, b});
`else
    skip     = (b == '0);
`endif
  end

  // The dividend register doubles as the quotient register: each shift
  // pushes one dividend bit out and one quotient bit in at the LSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      p           <= '0;
      dvd         <= '0;
      dvs         <= '0;
      short_op    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd         <= a;
            dvs         <= b;
            p           <= '0;
            div_by_zero <= 1'b0;
            short_op    <= skip;
            cnt         <= skip ? '0 : CW'(DW - 1);
            busy        <= 1'b1;
            state       <= CALC;
          end
        end
        CALC: begin
          // Short operations spend a single edge here so done lands at N+1.
          if (short_op) begin
            quotient    <= dvs_zero ? '1 : '0;
            remainder   <= dvd[VW-1:0];
            div_by_zero <= dvs_zero;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            p   <= p_nx;
            dvd <= dvd_nx;
            if (cnt == '0) begin
              quotient  <= dvd_nx;
              remainder <= p_nx[VW-1:0];
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dadda_divider_8by4.sv
// Directed self-checking bench for dadda_divider_8by4; latency expectations follow DADDA_DIV_EARLY_EXIT_EN.
module tb_dadda_divider_8by4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [3:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dadda_divider_8by4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  // Pulses start for one edge and returns the number of edges until done (-1 on timeout).
  task automatic run_div(input logic [7:0] ta, input logic [3:0] tb_v, output int lat, output logic busy1);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    lat = -1;
    if (done) lat = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (done) lat = k;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (quotient !== 8'd0) begin n_err++; $display("FAIL reset_quot got %0d want 0", quotient); end
    n_vec++; if (remainder !== 4'd0) begin n_err++; $display("FAIL reset_rem got %0d want 0", remainder); end
    n_vec++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    rst_n = 1'b1;
  endtask

  task automatic test_divide;
    logic [7:0] va [6] = '{8'd210, 8'd80, 8'd27, 8'd90, 8'd200, 8'd255};
    logic [3:0] vb [6] = '{4'd14, 4'd8, 4'd9, 4'd15, 4'd13, 4'd1};
    logic [7:0] vq [6] = '{8'd15, 8'd10, 8'd3, 8'd6, 8'd15, 8'd255};
    logic [3:0] vr [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0};
    int lat;
    logic bz;
    for (int i = 0; i < 6; i++) begin
      run_div(va[i], vb[i], lat, bz);
      n_vec++; if (bz !== 1'b1) begin n_err++; $display("FAIL div%0d_busy got %b want 1", i, bz); end
      n_vec++; if (lat != 8) begin n_err++; $display("FAIL div%0d_latency got %0d want 8", i, lat); end
      n_vec++; if (quotient !== vq[i]) begin n_err++; $display("FAIL div%0d_quot got %0d want %0d", i, quotient, vq[i]); end
      n_vec++; if (remainder !== vr[i]) begin n_err++; $display("FAIL div%0d_rem got %0d want %0d", i, remainder, vr[i]); end
      n_vec++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL div%0d_dbz got %b want 0", i, div_by_zero); end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic bz;
    run_div(8'd77, 4'd0, lat, bz);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL dz_latency got %0d want 1", lat); end
    n_vec++; if (quotient !== 8'hFF) begin n_err++; $display("FAIL dz_quot got %h want ff", quotient); end
    n_vec++; if (remainder !== 4'd13) begin n_err++; $display("FAIL dz_rem got %0d want 13", remainder); end
    n_vec++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
    repeat (3) @(negedge clk);
    n_vec++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_hold got %b want 1", div_by_zero); end
    run_div(8'd27, 4'd9, lat, bz);
    n_vec++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_clear got %b want 0", div_by_zero); end
    n_vec++; if (quotient !== 8'd3) begin n_err++; $display("FAIL dz_next_quot got %0d want 3", quotient); end
  endtask

  task automatic test_early_exit;
    int lat;
    int want_lat;
    logic bz;
`ifdef DADDA_DIV_EARLY_EXIT_EN
    want_lat = 1;
`else
    want_lat = 8;
`endif
    run_div(8'd7, 4'd9, lat, bz);
    n_vec++; if (lat != want_lat) begin n_err++; $display("FAIL early_latency got %0d want %0d", lat, want_lat); end
    n_vec++; if (quotient !== 8'd0) begin n_err++; $display("FAIL early_quot got %0d want 0", quotient); end
    n_vec++; if (remainder !== 4'd7) begin n_err++; $display("FAIL early_rem got %0d want 7", remainder); end
  endtask

  task automatic test_start_ignore;
    int lat;
    int extra;
    @(negedge clk);
    a = 8'd210; b = 4'd14; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'd1; b = 4'd1;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 3) start = 1'b0;
      if (done) lat = k;
    end
    start = 1'b0;
    n_vec++; if (lat != 8) begin n_err++; $display("FAIL ign_latency got %0d want 8", lat); end
    n_vec++; if (quotient !== 8'd15) begin n_err++; $display("FAIL ign_quot got %0d want 15", quotient); end
    n_vec++; if (remainder !== 4'd0) begin n_err++; $display("FAIL ign_rem got %0d want 0", remainder); end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL ign_no_second_op got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    a = 8'd210; b = 4'd14; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_vec++; if (quotient !== 8'd0) begin n_err++; $display("FAIL rmid_quot got %0d want 0", quotient); end
    n_vec++; if (remainder !== 4'd0) begin n_err++; $display("FAIL rmid_rem got %0d want 0", remainder); end
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL rmid_no_done got %0d dones want 0", seen); end
  endtask

  task automatic test_back_to_back;
    int first_t;
    int second_t;
    @(negedge clk);
    a = 8'd80; b = 4'd8; start = 1'b1;
    first_t = -1; second_t = -1;
    for (int k = 0; k < 40 && second_t < 0; k++) begin
      @(negedge clk);
      if (done) begin
        if (first_t < 0) first_t = k;
        else second_t = k;
      end
    end
    start = 1'b0;
    n_vec++; if (second_t < 0 || (second_t - first_t) != 10) begin
      n_err++; $display("FAIL b2b_period got %0d want 10", second_t - first_t);
    end
    n_vec++; if (quotient !== 8'd10) begin n_err++; $display("FAIL b2b_quot got %0d want 10", quotient); end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_early_exit();
    test_start_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
